// File: rtl/rx_tlp_dllp_arbiter_if.sv
// rx_tlp_dllp_arbiter_if: bus bundle between the RX packet filter, the TLP/DLLP
// arbiter and the data link layer.
//   tlp_in/tlp_valid, dllp_in/dllp_valid : class beats from the filter (no backpressure)
//   out_data/out_valid/out_is_dllp       : granted beat towards the data link layer
//   out_ready                            : sink accepts the current beat
//   ovf_clr, tlp_ovf, dllp_ovf           : sticky overflow flags and their clear strobe
//   tlp_grant_cnt, dllp_grant_cnt        : accepted-beat counters (only with RX_ARB_STATS_EN)
// modport slave is the arbiter side, modport master is the surrounding logic side.
interface rx_tlp_dllp_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tlp_in;
  logic                  tlp_valid;
  logic [DATA_WIDTH-1:0] dllp_in;
  logic                  dllp_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_is_dllp;
  logic                  out_ready;
  logic                  ovf_clr;
  logic                  tlp_ovf;
  logic                  dllp_ovf;
`ifdef RX_ARB_STATS_EN
  logic [15:0]           tlp_grant_cnt;
  logic [15:0]           dllp_grant_cnt;

  modport slave (
    input  tlp_in, tlp_valid, dllp_in, dllp_valid, out_ready, ovf_clr,
    output out_data, out_valid, out_is_dllp, tlp_ovf, dllp_ovf, tlp_grant_cnt, dllp_grant_cnt
  );

  modport master (
    output tlp_in, tlp_valid, dllp_in, dllp_valid, out_ready, ovf_clr,
    input  out_data, out_valid, out_is_dllp, tlp_ovf, dllp_ovf, tlp_grant_cnt, dllp_grant_cnt
  );
`else
  modport slave (
    input  tlp_in, tlp_valid, dllp_in, dllp_valid, out_ready, ovf_clr,
    output out_data, out_valid, out_is_dllp, tlp_ovf, dllp_ovf
  );

  modport master (
    output tlp_in, tlp_valid, dllp_in, dllp_valid, out_ready, ovf_clr,
    input  out_data, out_valid, out_is_dllp, tlp_ovf, dllp_ovf
  );
`endif
endinterface

// File: rtl/rx_tlp_dllp_arbiter.sv
// rx_tlp_dllp_arbiter: buffers TLP and DLLP beats in one FIFO per class and
// merges them onto a single registered output. DLLPs have priority, but after
// MAX_DLLP_RUN consecutive DLLP grants with a TLP waiting, one TLP is forced out.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus_io : rx_tlp_dllp_arbiter_if.slave (inputs, output beat, overflow flags)
// Optional feature: define RX_ARB_STATS_EN to add saturating per-class counters
// of accepted output beats (bus_io.tlp_grant_cnt / bus_io.dllp_grant_cnt).
module rx_tlp_dllp_arbiter #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MAX_DLLP_RUN = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  rx_tlp_dllp_arbiter_if.slave bus_io
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] PtrOne   = (PtrW + 1)'(1);
  localparam logic [3:0]    MaxRun   = 4'(MAX_DLLP_RUN);
  localparam int unsigned Tlp  = 0;
  localparam int unsigned Dllp = 1;

  typedef enum logic [0:0] {SNormal, SForceTlp} state_e;

  state_e     state_q, state_d;
  logic [3:0] run_q, run_d;

  // Class FIFOs, index Tlp / Dllp. Pointers carry one extra wrap bit.
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [DATA_WIDTH-1:0] mem_q   [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head    [2];
  logic [PtrW:0]         wr_ptr_q [2];
  logic [PtrW:0]         rd_ptr_q [2];
  logic [PtrW:0]         fill     [2];
  logic [1:0]            in_valid, fifo_ne, fifo_full, push, pop, ovf_set;
  logic [1:0]            ovf_q, ovf_d;

  logic                  load;
  logic                  out_valid_q, out_valid_d;
  logic                  out_is_dllp_q, out_is_dllp_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  assign in_valid      = {bus_io.dllp_valid, bus_io.tlp_valid};
  assign in_data[Tlp]  = bus_io.tlp_in;
  assign in_data[Dllp] = bus_io.dllp_in;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      fill[c]      = wr_ptr_q[c] - rd_ptr_q[c];
      fifo_ne[c]   = (fill[c] != '0);
      fifo_full[c] = (fill[c] == DepthCnt);
      head[c]      = mem_q[c][rd_ptr_q[c][PtrW-1:0]];
    end
  end

  // A full FIFO still accepts when its head leaves in the same cycle.
  assign push    = in_valid & (~fifo_full | pop);
  assign ovf_set = in_valid & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PtrOne;
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PtrOne;
      end
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c][PtrW-1:0]] <= in_data[c];
    end
  end

  // Load opportunity: output register empty or being drained this cycle.
  assign load = ~out_valid_q | bus_io.out_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SNormal;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // FSM: next state and DLLP run counter
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      SNormal: begin
        if (pop[Dllp] && fifo_ne[Tlp]) begin
          run_d = run_q + 4'd1;
        end else if (pop[Tlp]) begin
          run_d = 4'd0;
        end
        if (!fifo_ne[Tlp]) run_d = 4'd0;
        if (run_d == MaxRun) state_d = SForceTlp;
      end
      SForceTlp: begin
        if (pop[Tlp] || !fifo_ne[Tlp]) begin
          state_d = SNormal;
          run_d   = 4'd0;
        end
      end
      default: begin
        state_d = SNormal;
        run_d   = 4'd0;
      end
    endcase
  end

  // FSM: grant outputs (a grant pops the head of the granted FIFO)
  always_comb begin
    pop = 2'b00;
    if (load) begin
      unique case (state_q)
        SNormal: begin
          if (fifo_ne[Dllp])     pop[Dllp] = 1'b1;
          else if (fifo_ne[Tlp]) pop[Tlp]  = 1'b1;
        end
        SForceTlp: pop[Tlp] = fifo_ne[Tlp];
        default:   pop      = 2'b00;
      endcase
    end
  end

  // Output register; holds its contents while stalled.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_is_dllp_d = out_is_dllp_q;
    if (load) begin
      out_valid_d = |pop;
      if (pop[Dllp]) begin
        out_data_d    = head[Dllp];
        out_is_dllp_d = 1'b1;
      end else if (pop[Tlp]) begin
        out_data_d    = head[Tlp];
        out_is_dllp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_is_dllp_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_is_dllp_q <= out_is_dllp_d;
    end
  end

  // Sticky overflow: a new overflow wins over a simultaneous clear.
  assign ovf_d = ovf_set | (ovf_q & {2{~bus_io.ovf_clr}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 2'b00;
    else        ovf_q <= ovf_d;
  end

  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.out_data    = out_data_q;
  assign bus_io.out_is_dllp = out_is_dllp_q;
  assign bus_io.tlp_ovf     = ovf_q[Tlp];
  assign bus_io.dllp_ovf    = ovf_q[Dllp];

`ifdef RX_ARB_STATS_EN
  logic        accept;
  logic [15:0] tlp_cnt_q, tlp_cnt_d, dllp_cnt_q, dllp_cnt_d;

  assign accept = out_valid_q & bus_io.out_ready;

  // Increment takes precedence over ovf_clr; counters saturate.
  always_comb begin
    tlp_cnt_d  = bus_io.ovf_clr ? 16'd0 : tlp_cnt_q;
    dllp_cnt_d = bus_io.ovf_clr ? 16'd0 : dllp_cnt_q;
    if (accept && !out_is_dllp_q) begin
      tlp_cnt_d = (tlp_cnt_q == 16'hFFFF) ? 16'hFFFF : tlp_cnt_q + 16'd1;
    end
    if (accept && out_is_dllp_q) begin
      dllp_cnt_d = (dllp_cnt_q == 16'hFFFF) ? 16'hFFFF : dllp_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_cnt_q  <= 16'd0;
      dllp_cnt_q <= 16'd0;
    end else begin
      tlp_cnt_q  <= tlp_cnt_d;
      dllp_cnt_q <= dllp_cnt_d;
    end
  end

  assign bus_io.tlp_grant_cnt  = tlp_cnt_q;
  assign bus_io.dllp_grant_cnt = dllp_cnt_q;
`endif

endmodule

// File: tb/tb_rx_tlp_dllp_arbiter.sv
// tb_rx_tlp_dllp_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a queue-based reference model of the arbiter.
// Build with RX_ARB_STATS_EN defined to also check the grant counters.
module tb_rx_tlp_dllp_arbiter;

  localparam int unsigned W      = 128;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAXRUN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_tlp_dllp_arbiter_if #(.DATA_WIDTH(W)) bus ();

  rx_tlp_dllp_arbiter #(
    .DATA_WIDTH  (W),
    .FIFO_DEPTH  (DEPTH),
    .MAX_DLLP_RUN(MAXRUN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] tq[$];
  logic [W-1:0] dq[$];
  logic         exp_valid;
  logic [W-1:0] exp_data;
  logic         exp_is_dllp;
  logic         exp_tovf, exp_dovf;
  int           streak;
  logic [15:0]  exp_tcnt, exp_dcnt;

  // Output order capture
  bit           collecting = 1'b0;
  logic [15:0]  seq;
  int           nbeats;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    tq.delete();
    dq.delete();
    exp_valid   = 1'b0;
    exp_data    = '0;
    exp_is_dllp = 1'b0;
    exp_tovf    = 1'b0;
    exp_dovf    = 1'b0;
    streak      = 0;
    exp_tcnt    = 16'd0;
    exp_dcnt    = 16'd0;
  endtask

  // One rising edge of the reference model, from the inputs being presented.
  task automatic model_step();
    bit accepted, load, tlp_waiting, gt, gd;
    logic [15:0] tnew, dnew;
    accepted = exp_valid && bus.out_ready;
    tnew = bus.ovf_clr ? 16'd0 : exp_tcnt;
    dnew = bus.ovf_clr ? 16'd0 : exp_dcnt;
    if (accepted && !exp_is_dllp) tnew = (exp_tcnt == 16'hFFFF) ? 16'hFFFF : exp_tcnt + 16'd1;
    if (accepted &&  exp_is_dllp) dnew = (exp_dcnt == 16'hFFFF) ? 16'hFFFF : exp_dcnt + 16'd1;
    exp_tcnt = tnew;
    exp_dcnt = dnew;

    load        = !exp_valid || bus.out_ready;
    tlp_waiting = (tq.size() != 0);
    gt = 1'b0;
    gd = 1'b0;
    if (load) begin
      if (streak >= MAXRUN)   gt = tlp_waiting;
      else if (dq.size() != 0) gd = 1'b1;
      else                    gt = tlp_waiting;
    end
    if (gt) streak = 0;
    else if (gd && tlp_waiting) streak++;
    if (!tlp_waiting) streak = 0;

    if (load) begin
      exp_valid = gt || gd;
      if (gd) begin
        exp_data    = dq.pop_front();
        exp_is_dllp = 1'b1;
      end else if (gt) begin
        exp_data    = tq.pop_front();
        exp_is_dllp = 1'b0;
      end
    end

    if (bus.ovf_clr) begin
      exp_tovf = 1'b0;
      exp_dovf = 1'b0;
    end
    if (bus.tlp_valid) begin
      if (tq.size() < DEPTH) tq.push_back(bus.tlp_in);
      else                   exp_tovf = 1'b1;
    end
    if (bus.dllp_valid) begin
      if (dq.size() < DEPTH) dq.push_back(bus.dllp_in);
      else                   exp_dovf = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    check_eq("out_valid", bus.out_valid, exp_valid);
    if (exp_valid) begin
      check_eq("out_data", bus.out_data, exp_data);
      check_eq("out_is_dllp", bus.out_is_dllp, exp_is_dllp);
    end
    check_eq("tlp_ovf", bus.tlp_ovf, exp_tovf);
    check_eq("dllp_ovf", bus.dllp_ovf, exp_dovf);
`ifdef RX_ARB_STATS_EN
    check_eq("tlp_grant_cnt", bus.tlp_grant_cnt, exp_tcnt);
    check_eq("dllp_grant_cnt", bus.dllp_grant_cnt, exp_dcnt);
`endif
  endtask

  // Called at a falling edge: present inputs, take one rising edge, check.
  task automatic step(input bit tv, input logic [W-1:0] td, input bit dv,
                      input logic [W-1:0] dd, input bit rdy, input bit clr);
    bus.tlp_valid  = tv;
    bus.tlp_in     = td;
    bus.dllp_valid = dv;
    bus.dllp_in    = dd;
    bus.out_ready  = rdy;
    bus.ovf_clr    = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
    if (collecting && bus.out_valid) begin
      seq = {seq[14:0], bus.out_is_dllp};
      nbeats++;
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, 1'b0, '0, rdy, 1'b0);
  endtask

  // Asserts reset between clock edges; outputs must clear without a clock.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    bus.tlp_valid  = 1'b0;
    bus.dllp_valid = 1'b0;
    bus.ovf_clr    = 1'b0;
    #1;
    check_eq("rst_async_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_async_out_data", bus.out_data, '0);
    check_eq("rst_async_tlp_ovf", bus.tlp_ovf, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] t_beat, d_beat;
    int unsigned  pv, pr;
    bus.tlp_valid  = 1'b0;
    bus.tlp_in     = '0;
    bus.dllp_valid = 1'b0;
    bus.dllp_in    = '0;
    bus.out_ready  = 1'b0;
    bus.ovf_clr    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("reset_out_valid", bus.out_valid, 1'b0);
    check_eq("reset_out_data", bus.out_data, '0);
    check_eq("reset_out_is_dllp", bus.out_is_dllp, 1'b0);
    check_eq("reset_tlp_ovf", bus.tlp_ovf, 1'b0);
    check_eq("reset_dllp_ovf", bus.dllp_ovf, 1'b0);
    rst_n = 1'b1;

    // Single TLP: visible after the second edge, for exactly one cycle
    t_beat = {4{32'h1111_1111}};
    step(1'b1, t_beat, 1'b0, '0, 1'b1, 1'b0);
    check_eq("single_tlp_no_bypass", bus.out_valid, 1'b0);
    idle(1'b1);
    check_eq("single_tlp_valid", bus.out_valid, 1'b1);
    check_eq("single_tlp_data", bus.out_data, t_beat);
    check_eq("single_tlp_is_dllp", bus.out_is_dllp, 1'b0);
    idle(1'b1);
    check_eq("single_tlp_one_cycle", bus.out_valid, 1'b0);

    // Simultaneous TLP and DLLP: DLLP first
    t_beat = rand_beat();
    d_beat = rand_beat();
    step(1'b1, t_beat, 1'b1, d_beat, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("both_first_is_dllp", bus.out_is_dllp, 1'b1);
    check_eq("both_first_data", bus.out_data, d_beat);
    idle(1'b1);
    check_eq("both_second_is_tlp", bus.out_is_dllp, 1'b0);
    check_eq("both_second_data", bus.out_data, t_beat);
    idle(1'b1);

    // DLLP run limit: one TLP waiting behind 8 DLLPs
    collecting = 1'b1;
    seq        = '0;
    nbeats     = 0;
    step(1'b1, rand_beat(), 1'b1, rand_beat(), 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, rand_beat(), 1'b1, 1'b0);
    repeat (6) idle(1'b1);
    collecting = 1'b0;
    check_eq("run_order", seq, 16'b1_1110_1111);
    check_eq("run_beats", nbeats, 9);

    // Stalled output: 1 held + 4 buffered, 6th TLP overflows, then clear
    for (int i = 0; i < 5; i++) step(1'b1, rand_beat(), 1'b0, '0, 1'b0, 1'b0);
    check_eq("fill_no_ovf", bus.tlp_ovf, 1'b0);
    step(1'b1, rand_beat(), 1'b0, '0, 1'b0, 1'b0);
    check_eq("fill_tlp_ovf_set", bus.tlp_ovf, 1'b1);
    check_eq("fill_dllp_ovf_clear", bus.dllp_ovf, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("ovf_cleared", bus.tlp_ovf, 1'b0);
    repeat (3) idle(1'b0);

    // Mid-transfer reset discards everything
    apply_reset();
    idle(1'b1);
    check_eq("post_rst_empty_0", bus.out_valid, 1'b0);
    idle(1'b1);
    check_eq("post_rst_empty_1", bus.out_valid, 1'b0);

    // 3 TLPs and 2 DLLPs accepted after reset
    step(1'b1, rand_beat(), 1'b0, '0, 1'b1, 1'b0);
    check_eq("post_rst_latency", bus.out_valid, 1'b0);
    step(1'b0, '0, 1'b1, rand_beat(), 1'b1, 1'b0);
    step(1'b1, rand_beat(), 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, rand_beat(), 1'b1, 1'b0);
    step(1'b1, rand_beat(), 1'b0, '0, 1'b1, 1'b0);
    repeat (4) idle(1'b1);
`ifdef RX_ARB_STATS_EN
    check_eq("stats_tlp_cnt", bus.tlp_grant_cnt, 16'd3);
    check_eq("stats_dllp_cnt", bus.dllp_grant_cnt, 16'd2);
`endif

    // Randomized traffic in phases of varying load and backpressure
    for (int ph = 0; ph < 4; ph++) begin
      pv = (ph == 0) ? 30 : (ph == 1) ? 60 : (ph == 2) ? 90 : 50;
      pr = (ph == 0) ? 90 : (ph == 1) ? 60 : (ph == 2) ? 30 : 75;
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 99) < pv, rand_beat(),
             $urandom_range(0, 99) < pv, rand_beat(),
             $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 3);
      end
      if (ph == 1) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_tlp_dllp_arbiter.md
RX_TLP_DLLP_ARBITER -- requirements
Module: rx_tlp_dllp_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set beat width of all data ports.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set entries per class FIFO; legal values are powers of two >= 2.
REQ-003 Parameter MAX_DLLP_RUN, default 4, SHALL set the maximum consecutive DLLP grants while a TLP is pending; legal range 1..15.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 tlp_in  input  DATA_WIDTH  SHALL carry the TLP beat from the packet filter.
REQ-007 tlp_valid  input  1  SHALL qualify tlp_in; no backpressure.
REQ-008 dllp_in  input  DATA_WIDTH  SHALL carry the DLLP beat from the packet filter.
REQ-009 dllp_valid  input  1  SHALL qualify dllp_in; no backpressure.
REQ-010 out_data  output  DATA_WIDTH  SHALL carry the granted beat to the data link layer.
REQ-011 out_valid  output  1  SHALL indicate that out_data holds a beat.
REQ-012 out_is_dllp  output  1  SHALL be 1 for a DLLP beat and 0 for a TLP beat.
REQ-013 out_ready  input  1  SHALL accept the beat when high with out_valid.
REQ-014 ovf_clr  input  1  SHALL clear the sticky overflow flags when pulsed.
REQ-015 tlp_ovf, dllp_ovf  output  1 each  SHALL be sticky per-class overflow flags.

Function
REQ-016 Each class SHALL have its own FIFO of FIFO_DEPTH entries; a beat with valid high SHALL be written at the rising edge when the FIFO is not full or is popped in the same cycle.
REQ-017 When valid is high, the FIFO is full and not popped that cycle, the beat SHALL be dropped and the matching _ovf flag set; set SHALL win over a simultaneous ovf_clr.
REQ-018 tlp_valid and dllp_valid high together SHALL push both FIFOs independently.
REQ-019 The output register SHALL load when out_valid is 0 or out_valid & out_ready is 1, from the granted FIFO head, and pop that FIFO in the same cycle.
REQ-020 out_data and out_is_dllp SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Minimum latency SHALL be 2 cycles: a beat sampled at edge k appears with out_valid=1 after edge k+1; there is no bypass.
REQ-022 Sustained throughput SHALL be one beat per cycle while out_ready=1 and either FIFO is non-empty.
REQ-023 Arbitration FSM states SHALL be S_NORMAL and S_FORCE_TLP.
REQ-024 In S_NORMAL, DLLP SHALL be granted if its FIFO is non-empty, else TLP if non-empty.
REQ-025 A 4-bit run counter SHALL increment on each DLLP grant while the TLP FIFO is non-empty, and clear on any TLP grant or whenever the TLP FIFO is empty.
REQ-026 When the run counter reaches MAX_DLLP_RUN, the FSM SHALL enter S_FORCE_TLP.
REQ-027 In S_FORCE_TLP the next load SHALL grant TLP; the FSM SHALL then return to S_NORMAL with the counter at 0.
REQ-028 In S_FORCE_TLP, if the TLP FIFO is empty the FSM SHALL return to S_NORMAL without granting.
REQ-029 With no load opportunity (output stalled), grant state and counter SHALL hold.

Reset
REQ-030 On rst_n low: both FIFOs empty, out_valid=0, out_data=0, out_is_dllp=0, tlp_ovf=0, dllp_ovf=0, counter=0, FSM=S_NORMAL.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered and held beats; the first post-reset beat SHALL observe the 2-cycle latency.

Configuration
REQ-032 With macro RX_ARB_STATS_EN defined: outputs tlp_grant_cnt[15:0] and dllp_grant_cnt[15:0] SHALL count accepted output beats per class, saturate at 16'hFFFF, clear on reset or ovf_clr, and increment over a simultaneous ovf_clr.
REQ-033 Without RX_ARB_STATS_EN, these ports and counters SHALL be absent; all other behaviour is unchanged.

Verification
REQ-034 Single TLP 0x11..11 at cycle 0, out_ready=1 -> out_valid=1, out_is_dllp=0, out_data=0x11..11 after edge 1, for one cycle.
REQ-035 TLP and DLLP pushed in the same cycle, out_ready=1 -> DLLP output first, TLP next cycle.
REQ-036 TLP queued, 8 DLLPs back-to-back, MAX_DLLP_RUN=4 -> output order D,D,D,D,T,D,D,D,D.
REQ-037 out_ready=0, 5 TLPs pushed, FIFO_DEPTH=4 -> 1 held in output, 4 buffered, no overflow; 6th TLP -> tlp_ovf=1, beat dropped; ovf_clr -> tlp_ovf=0.
REQ-038 Output held with out_ready=0 for 3 cycles -> out_data stable; rst_n pulsed low -> out_valid=0 immediately, FIFOs empty.
REQ-039 RX_ARB_STATS_EN defined, 3 TLP and 2 DLLP beats accepted -> tlp_grant_cnt=3, dllp_grant_cnt=2.
